// File: rtl/instr_encoder.sv
// Packs field-level MIPS instruction requests into 32-bit words, buffers them and
// streams them to instruction memory at sequential addresses. Optional NOP_PAD_EN adds branch delay padding.
module instr_encoder #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4,
   parameter int          NOP_COUNT  = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic        in_last_i,
   input  logic [5:0]  op_i,
   input  logic [4:0]  rs_i,
   input  logic [4:0]  rt_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  shamt_i,
   input  logic [5:0]  funct_i,
   input  logic [15:0] imm_i,
   output logic        imem_we_o,
   output logic [31:0] imem_addr_o,
   output logic [31:0] imem_data_o,
   input  logic        imem_ready_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [15:0] word_cnt_o
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;

`ifdef NOP_PAD_EN
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_PAD} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;
`endif

   state_t         state_q;
   logic [31:0]    fifo_q [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]  count_q;
   logic [31:0]    addr_q;
   logic [15:0]    cnt_q;
   logic           err_q;
   logic           done_q;

   logic           fifo_full, fifo_empty;
   logic           accept, push, pop;
   logic [31:0]    enc_word, push_word;
   logic           enc_legal;

   assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign in_ready_o = (state_q == S_RUN) && !fifo_full;
   assign accept     = in_valid_i && in_ready_o;
   assign pop        = !fifo_empty && imem_ready_i;

   always_comb begin
      enc_word  = 32'h0;
      enc_legal = 1'b0;
      case (op_i)
         6'd0: begin
            enc_word  = {op_i, rs_i, rt_i, rd_i, shamt_i, funct_i};
            enc_legal = 1'b1;
         end
         6'd4, 6'd5, 6'd8, 6'd13, 6'd35, 6'd43: begin
            enc_word  = {op_i, rs_i, rt_i, imm_i};
            enc_legal = 1'b1;
         end
         6'd15: begin
            enc_word  = {op_i, 5'd0, rt_i, imm_i};
            enc_legal = 1'b1;
         end
         default: begin
            enc_word  = 32'h0;
            enc_legal = 1'b0;
         end
      endcase
   end

`ifdef NOP_PAD_EN
   logic [15:0] pad_cnt_q;
   logic        pad_last_q;
   logic        pad_push;
   logic        is_branch;

   assign is_branch = (op_i == 6'd4) || (op_i == 6'd5);
   assign pad_push  = (state_q == S_PAD) && !fifo_full && (pad_cnt_q != 16'd0);
   assign push      = (accept && enc_legal) || pad_push;
   assign push_word = pad_push ? 32'h0 : enc_word;
`else
   assign push      = accept && enc_legal;
   assign push_word = enc_word;
`endif

   // Storage needs no reset: occupancy is tracked by count_q alone.
   always_ff @(posedge clk_i) begin
      if (push) fifo_q[wr_ptr_q] <= push_word;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         addr_q   <= BASE_ADDR;
         cnt_q    <= 16'd0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
`ifdef NOP_PAD_EN
         pad_cnt_q  <= 16'd0;
         pad_last_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            addr_q   <= addr_q + 32'd4;
            if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
         end
         count_q <= count_q + CW'(push) - CW'(pop);

         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q <= S_RUN;
                  addr_q  <= BASE_ADDR;
                  cnt_q   <= 16'd0;
                  err_q   <= 1'b0;
               end
            end
            S_RUN: begin
               if (accept) begin
                  if (!enc_legal) err_q <= 1'b1;
`ifdef NOP_PAD_EN
                  if (is_branch) begin
                     state_q    <= S_PAD;
                     pad_cnt_q  <= 16'(NOP_COUNT);
                     pad_last_q <= in_last_i;
                  end else if (in_last_i) begin
                     state_q <= S_FLUSH;
                  end
`else
                  if (in_last_i) state_q <= S_FLUSH;
`endif
               end
            end
            S_FLUSH: begin
               if (fifo_empty) begin
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
`ifdef NOP_PAD_EN
            S_PAD: begin
               // Leave on the final pad push (or at once when no padding is configured).
               if (pad_cnt_q == 16'd0) begin
                  state_q <= pad_last_q ? S_FLUSH : S_RUN;
               end else if (pad_push) begin
                  pad_cnt_q <= pad_cnt_q - 16'd1;
                  if (pad_cnt_q == 16'd1) state_q <= pad_last_q ? S_FLUSH : S_RUN;
               end
            end
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign imem_we_o   = !fifo_empty;
   assign imem_addr_o = addr_q;
   assign imem_data_o = fifo_q[rd_ptr_q];
   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign word_cnt_o  = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a queue-based reference model checks every memory write,
// the word counter and the error flag each cycle; literal expectations pin the model.
module tb_instr_encoder;

   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int          NOPS = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready_o;
   logic        in_last = 1'b0;
   logic [5:0]  op = '0;
   logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
   logic [5:0]  funct = '0;
   logic [15:0] imm = '0;
   logic        imem_we_o;
   logic [31:0] imem_addr_o, imem_data_o;
   logic        imem_ready = 1'b1;
   logic        busy_o, done_o, err_o;
   logic [15:0] word_cnt_o;

   int checks = 0;
   int errors = 0;

   instr_encoder dut (
      .clk_i(clk), .rst_i(rst), .start_i(start),
      .in_valid_i(in_valid), .in_ready_o(in_ready_o), .in_last_i(in_last),
      .op_i(op), .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt), .funct_i(funct), .imm_i(imm),
      .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_data_o(imem_data_o),
      .imem_ready_i(imem_ready), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .word_cnt_o(word_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference encoding taken straight from the MIPS field layouts; bit 32 = legal.
   function automatic logic [32:0] model_word(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                                              input logic [4:0] d, input logic [4:0] sh, input logic [5:0] f,
                                              input logic [15:0] i);
      logic [31:0] w;
      w = 32'h0;
      if (o == 6'd0) begin
         w = (32'(o) << 26) | (32'(s) << 21) | (32'(t) << 16) | (32'(d) << 11) | (32'(sh) << 6) | 32'(f);
         return {1'b1, w};
      end
      if (o == 6'd4 || o == 6'd5 || o == 6'd8 || o == 6'd13 || o == 6'd35 || o == 6'd43) begin
         w = (32'(o) << 26) | (32'(s) << 21) | (32'(t) << 16) | 32'(i);
         return {1'b1, w};
      end
      if (o == 6'd15) begin
         w = (32'(o) << 26) | (32'(t) << 16) | 32'(i);
         return {1'b1, w};
      end
      return {1'b0, w};
   endfunction

   logic [31:0] exp_q[$];
   logic [15:0] mcnt = 16'd0;
   logic        merr = 1'b0;
   int          mwr = 0;
   logic [31:0] log_dat [64];
   logic [31:0] log_adr [64];
   int          log_n = 0;

   always @(negedge clk) begin
      logic [32:0] mw;
      if (rst) begin
         exp_q.delete();
         mcnt = 16'd0;
         merr = 1'b0;
         mwr  = 0;
      end else begin
         chk("word_cnt", 32'(word_cnt_o), 32'(mcnt));
         chk("err", 32'(err_o), 32'(merr));
         if (imem_we_o && imem_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_write", imem_data_o, 32'hDEAD_BEEF);
            end else begin
               chk("wr_data", imem_data_o, exp_q[0]);
               chk("wr_addr", imem_addr_o, BASE + 32'(mwr) * 32'd4);
               void'(exp_q.pop_front());
            end
            if (log_n < 64) begin
               log_dat[log_n] = imem_data_o;
               log_adr[log_n] = imem_addr_o;
            end
            log_n++;
            mwr++;
            if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
         end
         if (start && !busy_o) begin
            mcnt = 16'd0;
            merr = 1'b0;
            mwr  = 0;
         end
         if (in_valid && in_ready_o) begin
            mw = model_word(op, rs, rt, rd, shamt, funct, imm);
            if (mw[32]) begin
               exp_q.push_back(mw[31:0]);
`ifdef NOP_PAD_EN
               if (op == 6'd4 || op == 6'd5)
                  for (int k = 0; k < NOPS; k++) exp_q.push_back(32'h0);
`endif
            end else begin
               merr = 1'b1;
            end
         end
      end
   end

   task automatic do_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic drive(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                        input logic [4:0] sh, input logic [5:0] f, input logic [15:0] i, input logic last);
      op = o; rs = s; rt = t; rd = d; shamt = sh; funct = f; imm = i; in_last = last;
      in_valid = 1'b1;
   endtask

   task automatic wait_accept();
      bit acc;
      acc = 1'b0;
      for (int c = 0; c < 100 && !acc; c++) begin
         @(negedge clk);
         acc = in_ready_o;
         @(posedge clk); #1;
      end
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                       input logic [4:0] sh, input logic [5:0] f, input logic [15:0] i, input logic last);
      @(posedge clk); #1;
      drive(o, s, t, d, sh, f, i, last);
      wait_accept();
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         @(negedge clk);
         seen = done_o;
      end
      chk("done_pulse", 32'(seen), 32'd1);
      @(negedge clk);
      chk("done_one_cycle", 32'(done_o), 32'd0);
      chk("idle_after_done", 32'(busy_o), 32'd0);
      chk("model_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic chk_reset_state();
      chk("rst_in_ready", 32'(in_ready_o), 32'd0);
      chk("rst_imem_we", 32'(imem_we_o), 32'd0);
      chk("rst_addr", imem_addr_o, BASE);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      chk("rst_word_cnt", 32'(word_cnt_o), 32'd0);
   endtask

   int base;

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk_reset_state();
      @(posedge clk); #1 rst = 1'b0;

      // ADDI then R-format add
      base = log_n;
      do_start();
      chk("busy_after_start", 32'(busy_o), 32'd1);
      send(6'd8, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 1'b0);
      send(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 1'b1);
      wait_done();
      chk("t2_n", 32'(log_n - base), 32'd2);
      chk("t2_w0", log_dat[base], 32'h2008_0005);
      chk("t2_a0", log_adr[base], 32'h0000_0000);
      chk("t2_w1", log_dat[base+1], 32'h0022_1820);
      chk("t2_a1", log_adr[base+1], 32'h0000_0004);
      chk("t2_cnt", 32'(word_cnt_o), 32'd2);

      // LW and LUI (rs ignored)
      base = log_n;
      do_start();
      send(6'd35, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd4, 1'b0);
      send(6'd15, 5'd5, 5'd1, 5'd0, 5'd0, 6'd0, 16'h1234, 1'b1);
      wait_done();
      chk("t3_w0", log_dat[base], 32'h8C22_0004);
      chk("t3_a0", log_adr[base], 32'h0000_0000);
      chk("t3_w1", log_dat[base+1], 32'h3C01_1234);

      // Back-pressure: FIFO fills at 4 entries
      base = log_n;
      imem_ready = 1'b0;
      do_start();
      for (int k = 0; k < 4; k++)
         send(6'd8, 5'd0, 5'(k + 1), 5'd0, 5'd0, 6'd0, 16'(k + 1), 1'b0);
      drive(6'd13, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h00FF, 1'b1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t4_full_ready", 32'(in_ready_o), 32'd0);
         chk("t4_full_we", 32'(imem_we_o), 32'd1);
         @(posedge clk); #1;
      end
      imem_ready = 1'b1;
      wait_accept();
      wait_done();
      chk("t4_n", 32'(log_n - base), 32'd5);
      chk("t4_w0", log_dat[base], 32'h2001_0001);
      chk("t4_w4", log_dat[base+4], 32'h3464_00FF);
      chk("t4_a4", log_adr[base+4], 32'h0000_0010);
      chk("t4_cnt", 32'(word_cnt_o), 32'd5);

      // Illegal opcode as the last request
      base = log_n;
      do_start();
      send(6'd2, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1111, 1'b1);
      wait_done();
      chk("t5_err", 32'(err_o), 32'd1);
      chk("t5_nowrite", 32'(log_n - base), 32'd0);
      do_start();
      @(negedge clk);
      chk("t5_err_cleared", 32'(err_o), 32'd0);
      send(6'd8, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'hFFFF, 1'b1);
      wait_done();
      chk("t5_cnt", 32'(word_cnt_o), 32'd1);

      // Reset mid-run with words buffered and err set
      imem_ready = 1'b0;
      do_start();
      send(6'd63, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 1'b0);
      send(6'd8, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'd7, 1'b0);
      send(6'd43, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd8, 1'b0);
      @(negedge clk);
      chk("t7_err_pre", 32'(err_o), 32'd1);
      chk("t7_we_pre", 32'(imem_we_o), 32'd1);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      chk_reset_state();
      @(posedge clk); #1 rst = 1'b0;
      imem_ready = 1'b1;
      @(negedge clk);
      chk_reset_state();

      // Branch as last request (padded only when NOP_PAD_EN)
      base = log_n;
      do_start();
      send(6'd4, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd3, 1'b1);
      wait_done();
      chk("t6_w0", log_dat[base], 32'h1022_0003);
`ifdef NOP_PAD_EN
      chk("t6_n", 32'(log_n - base), 32'd4);
      chk("t6_w3", log_dat[base+3], 32'h0000_0000);
      chk("t6_a3", log_adr[base+3], 32'h0000_000C);
      chk("t6_cnt", 32'(word_cnt_o), 32'd4);
`else
      chk("t6_n", 32'(log_n - base), 32'd1);
      chk("t6_cnt", 32'(word_cnt_o), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
